debouncer_array: RTL
====================

DEBOUNCER_ARRAY -- requirements
Module: debouncer_array

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels, legal range 1..32.
REQ-002 Parameter TICK_DIV, default 50000: system clocks per sample tick, legal range >= 1.
REQ-003 Parameter STABLE_COUNT, default 10: consecutive differing ticks required to accept a new level, legal range >= 1.
REQ-004 Parameter ACTIVE_LOW, default 0: when 1, each raw input is inverted before synchronisation.
REQ-005 clock  input  1  single system clock, all state on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 signal  input  CHANNELS  raw asynchronous button/switch inputs.
REQ-008 db_signal  output  CHANNELS  debounced level per channel.
REQ-009 rise  output  CHANNELS  one-cycle pulse per channel when db_signal goes 0->1.
REQ-010 fall  output  CHANNELS  one-cycle pulse per channel when db_signal goes 1->0.
REQ-011 any_change  output  1  OR of all rise and fall bits, same cycle.

Function
REQ-012 Prescaler counts 0..TICK_DIV-1 and wraps; tick is high for one clock when count == TICK_DIV-1; with TICK_DIV=1, tick is high every cycle.
REQ-013 First tick after reset release occurs on clock edge TICK_DIV (1-based), then every TICK_DIV clocks; one prescaler is shared by all channels.
REQ-014 Each channel passes signal (after optional inversion) through a two-flop synchroniser; only the second flop output (sync) feeds the logic.
REQ-015 Per-channel stable counter, width clog2(STABLE_COUNT+1), clears on any clock where sync == db_signal, independent of tick.
REQ-016 On a tick with sync != db_signal: if counter == STABLE_COUNT-1, db_signal <= sync and counter <= 0; otherwise counter increments.
REQ-017 Counter never exceeds STABLE_COUNT-1; no wrap-around is possible.
REQ-018 rise/fall are registered and asserted exactly in the clock cycle in which the new db_signal value first appears, for one cycle only.
REQ-019 rise and fall of the same channel are never high together; different channels may pulse in the same cycle.
REQ-020 A glitch shorter than one tick period, or any return of sync to db_signal before acceptance, restarts qualification from zero.
REQ-021 Latency from a clean input step to db_signal change: 2 synchroniser clocks + time to STABLE_COUNT ticks, i.e. between 2+(STABLE_COUNT-1)*TICK_DIV+1 and 2+STABLE_COUNT*TICK_DIV clocks.
REQ-022 Channels are fully independent; activity on one channel has no effect on another's counter or outputs.

Reset
REQ-023 While reset_n is low: prescaler, synchronisers, counters, db_signal, rise, fall, any_change all 0 (synchroniser 0 means inactive after inversion).
REQ-024 Reset asserted mid-qualification discards progress; after release qualification restarts from zero.
REQ-025 No rise/fall pulse is generated by reset assertion or release itself; an input held active through reset yields one rise pulse after normal qualification.

Structure
REQ-026 Shared package debounce_pkg holds default constants (DEF_TICK_DIV, DEF_STABLE_COUNT, MAX_CHANNELS) and the counter-width function.
REQ-027 Per-channel logic (synchroniser, counter, level, pulses) lives in sub-module debounce_channel, instantiated CHANNELS times with a shared tick input; prescaler stays in the top level.
REQ-028 Illegal parameter values are flagged at elaboration.

Verification (CHANNELS=4, TICK_DIV=4, STABLE_COUNT=3, ACTIVE_LOW=0 unless stated)
REQ-029 Clean step signal[0] 0->1 held -> db_signal[0]=1 within 10..14 clocks, rise[0] high exactly 1 cycle, any_change high same cycle, other channels unchanged.
REQ-030 signal[1] bounces 1-clock pulses every 3 clocks for 40 clocks, then stays 0 -> db_signal[1], rise[1], fall[1] stay 0 throughout.
REQ-031 signal[2] high 7 clocks then low -> no acceptance (at most 2 ticks); high 20 clocks -> rise[2] once; then low 20 clocks -> fall[2] once.
REQ-032 signal[0] and signal[3] step 0->1 on same edge -> rise[0] and rise[3] in same cycle, any_change single cycle.
REQ-033 reset_n pulled low 8 clocks into qualification of signal[1]=1, released after 3 clocks with input still high -> outputs 0 during reset, rise[1] 10..14 clocks after release.
REQ-034 ACTIVE_LOW=1, TICK_DIV=1, STABLE_COUNT=1, signal held 1 -> db_signal all 0; signal[0] 1->0 -> db_signal[0]=1 exactly 3 clocks later.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debouncer array.
//   DEF_TICK_DIV      default system clocks per sample tick
//   DEF_STABLE_COUNT  default number of qualifying ticks
//   MAX_CHANNELS      largest supported channel count
//   cnt_width()       stable-counter width for a given STABLE_COUNT
package debounce_pkg;

  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_STABLE_COUNT = 10;
  localparam int MAX_CHANNELS     = 32;

  // The counter has to hold 0..STABLE_COUNT-1; sized as clog2(STABLE_COUNT+1)
  // with a floor of one bit so STABLE_COUNT=1 still yields a legal vector.
  function automatic int cnt_width(input int stable_count);
    int w;
    w = $clog2(stable_count + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: optional inversion, two-flop synchroniser, stable
// counter advanced by the shared sample tick, debounced level and edge pulses.
// Ports:
//   clock      system clock, rising edge
//   reset_n    asynchronous active-low reset
//   tick       one-cycle sample strobe from the shared prescaler
//   signal     raw asynchronous input
//   db_signal  debounced level
//   rise/fall  one-cycle pulses coincident with the new db_signal value
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_COUNT = DEF_STABLE_COUNT,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic tick,
  input  logic signal,
  output logic db_signal,
  output logic rise,
  output logic fall
);

  localparam int             CW   = cnt_width(STABLE_COUNT);
  localparam logic [CW-1:0]  LAST = CW'(STABLE_COUNT - 1);

  logic          raw;
  logic [1:0]    sync_q;
  logic          sync;
  logic [CW-1:0] cnt;
  logic          accept;

  assign raw    = (ACTIVE_LOW != 0) ? ~signal : signal;
  assign sync   = sync_q[1];
  assign accept = tick && (sync != db_signal) && (cnt == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      cnt       <= '0;
      db_signal <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      // Pulses are registered alongside db_signal so they appear in the
      // same cycle as the new level.
      rise   <= accept & sync;
      fall   <= accept & ~sync;
      // Any agreement between sync and the accepted level throws away
      // partial qualification, whether or not a tick is present.
      if (sync == db_signal) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == LAST) begin
          db_signal <= sync;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debouncer_array.sv
// Array of independent button/switch debouncers sharing one sample-tick
// prescaler.
// Ports:
//   clock       system clock, rising edge
//   reset_n     asynchronous active-low reset
//   signal      raw asynchronous inputs, one per channel
//   db_signal   debounced levels
//   rise/fall   one-cycle edge pulses per channel
//   any_change  OR of all rise and fall bits
module debouncer_array
  import debounce_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_COUNT = DEF_STABLE_COUNT,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] signal,
  output logic [CHANNELS-1:0] db_signal,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_change
);

  generate
    if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
      $error("debouncer_array: CHANNELS must be 1..32");
    end
    if (TICK_DIV < 1) begin : g_bad_tick_div
      $error("debouncer_array: TICK_DIV must be >= 1");
    end
    if (STABLE_COUNT < 1) begin : g_bad_stable_count
      $error("debouncer_array: STABLE_COUNT must be >= 1");
    end
    if (ACTIVE_LOW != 0 && ACTIVE_LOW != 1) begin : g_bad_active_low
      $error("debouncer_array: ACTIVE_LOW must be 0 or 1");
    end
  endgenerate

  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST_DIV = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;

  // With TICK_DIV=1 the counter is stuck at 0 == LAST_DIV, so tick is
  // permanently high.
  assign tick = (pre_cnt == LAST_DIV);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
        .STABLE_COUNT (STABLE_COUNT),
        .ACTIVE_LOW   (ACTIVE_LOW)
      ) u_ch (
        .clock     (clock),
        .reset_n   (reset_n),
        .tick      (tick),
        .signal    (signal[i]),
        .db_signal (db_signal[i]),
        .rise      (rise[i]),
        .fall      (fall[i])
      );
    end
  endgenerate

  assign any_change = |(rise | fall);

endmodule
